// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the imem read port and
// holds one fetched instruction until the IF/ID latch takes it.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    input  logic        halt,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pcplus4_out,
    output logic [31:0] next_pc_out
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic [31:0] ipc_q, ipc_d;

    logic        acc;
    logic        is_run;
    logic        is_squash;
    logic [31:0] rpc;
    logic [31:0] pc_inc;

    // Handshake terms and the word-aligned redirect target.
    always_comb begin
        is_run    = (state_q == RUN);
        is_squash = (state_q == SQUASH);
        acc       = !valid_q || !stall;
        rpc       = redirect_pc & 32'hFFFF_FFFC;
        pc_inc    = pc_q + 32'd4;
    end

    // Memory request: the squash state keeps the abandoned request alive
    // until its hit arrives so the memory side sees a clean handshake.
    always_comb begin
        imemREN  = (is_run && acc) || is_squash;
        imemaddr = (state_q == HALTED) ? 32'h0 : pc_q;
    end

    // Next-state logic for the FSM, PC, saved target and output buffer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        ipc_d   = ipc_q;
        unique case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALTED;
                    valid_d = 1'b0;
                end else if (redirect && ihit) begin
                    pc_d    = rpc;
                    valid_d = 1'b0;
                end else if (redirect && imemREN) begin
                    tgt_d   = rpc;
                    valid_d = 1'b0;
                    state_d = SQUASH;
                end else if (redirect) begin
                    pc_d    = rpc;
                    valid_d = 1'b0;
                end else if (ihit && acc) begin
                    valid_d = 1'b1;
                    instr_d = imemload;
                    pcp4_d  = pc_inc;
                    ipc_d   = pc_q;
                    pc_d    = pc_inc;
                end else if (acc) begin
                    valid_d = 1'b0;
                end
            end
            SQUASH: begin
                valid_d = 1'b0;
                if (halt) begin
                    state_d = HALTED;
                end else if (redirect) begin
                    tgt_d = rpc;
                    if (ihit) begin
                        pc_d    = rpc;
                        state_d = RUN;
                    end
                end else if (ihit) begin
                    pc_d    = tgt_q;
                    state_d = RUN;
                end
            end
            HALTED: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = HALTED;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers; async reset clears the buffer immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            tgt_q   <= 32'h0;
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            ipc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            ipc_q   <= ipc_d;
        end
    end

    // Buffer drives the IF/ID latch inputs directly.
    always_comb begin
        valid_out   = valid_q;
        instr_out   = instr_q;
        pcplus4_out = pcp4_q;
        next_pc_out = ipc_q;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of
// expected {instruction, pc} entries.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        halt;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pcplus4_out;
    logic [31:0] next_pc_out;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    fetch_stage #(.PC_INIT(32'h0)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .imemREN(imemREN),
        .imemaddr(imemaddr),
        .ihit(ihit),
        .imemload(imemload),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .stall(stall),
        .halt(halt),
        .valid_out(valid_out),
        .instr_out(instr_out),
        .pcplus4_out(pcplus4_out),
        .next_pc_out(next_pc_out)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock of directed stimulus. Request signals are checked before
    // the edge; the buffer is checked against the scoreboard after it.
    task automatic step(input logic h, input logic r,
                        input logic [31:0] rpc, input logic s,
                        input logic hl, input logic exp_ren,
                        input logic [31:0] exp_addr, input logic push,
                        input logic exp_valid);
        logic        gone;
        logic [63:0] e;
        ihit        = h;
        redirect    = r;
        redirect_pc = rpc;
        stall       = s;
        halt        = hl;
        imemload    = h ? pat(exp_addr) : 32'hDEAD_BEEF;
        #1;
        chk("imemREN", {31'b0, imemREN}, {31'b0, exp_ren});
        chk("imemaddr", imemaddr, exp_addr);
        gone = valid_out && (!s || r || hl);
        if (push) sb.push_back({pat(exp_addr), exp_addr});
        @(posedge CLK);
        #1;
        if (gone && sb.size() > 0) void'(sb.pop_front());
        chk("valid_out", {31'b0, valid_out}, {31'b0, exp_valid});
        if (exp_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb[0];
                chk("instr_out", instr_out, e[63:32]);
                chk("next_pc_out", next_pc_out, e[31:0]);
                chk("pcplus4_out", pcplus4_out, e[31:0] + 32'd4);
            end
        end
    endtask

    initial begin
        nRST        = 1'b0;
        ihit        = 1'b0;
        imemload    = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        halt        = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_valid", {31'b0, valid_out}, 32'd0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_pcp4", pcplus4_out, 32'h0);
        chk("rst_npc", next_pc_out, 32'h0);
        chk("rst_addr", imemaddr, 32'h0);
        nRST = 1'b1;

        // Streaming with continuous hits.
        step(1, 0, 0, 0, 0, 1, 32'h0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 32'h4, 1, 1);
        // Three wait states at PC=8.
        step(0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h8, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h8, 1, 1);
        // Stall with full buffer: request drops, outputs hold.
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 1, 0, 0, 32'hC, 0, 1);
        step(1, 0, 0, 0, 0, 1, 32'hC, 1, 1);
        // Redirect mid-request at 0x10 -> SQUASH, target 0x100.
        step(0, 1, 32'h100, 0, 0, 1, 32'h10, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h10, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h10, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h100, 1, 1);
        // Redirect with same-cycle hit, unaligned target masked to 0x40.
        step(1, 1, 32'h41, 0, 0, 1, 32'h104, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h40, 1, 1);
        // Redirect while stalled with no request flushes the buffer.
        step(0, 1, 32'h200, 1, 0, 0, 32'h44, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h200, 1, 1);
        // PC wrap at the top of the address space.
        step(1, 1, 32'hFFFF_FFFC, 0, 0, 1, 32'h204, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1);
        step(1, 0, 0, 0, 0, 1, 32'h0, 1, 1);
        // Second redirect during SQUASH coinciding with the hit.
        step(0, 1, 32'h300, 0, 0, 1, 32'h4, 0, 0);
        step(1, 1, 32'h380, 0, 0, 1, 32'h4, 0, 0);
        step(1, 0, 0, 0, 0, 1, 32'h380, 1, 1);
        // Halt is permanent; redirect and hits are ignored.
        step(0, 0, 0, 0, 1, 1, 32'h384, 0, 0);
        step(1, 1, 32'h500, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        sb.delete();

        // Reset restarts at PC_INIT.
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        step(1, 0, 0, 0, 0, 1, 32'h0, 1, 1);

        // Async reset with a hit in flight.
        ihit     = 1'b1;
        imemload = pat(32'h4);
        #2;
        nRST = 1'b0;
        #1;
        chk("arst_valid", {31'b0, valid_out}, 32'd0);
        chk("arst_instr", instr_out, 32'h0);
        chk("arst_pcp4", pcplus4_out, 32'h0);
        chk("arst_npc", next_pc_out, 32'h0);
        @(posedge CLK);
        #1;
        chk("arst_hit_ign", {31'b0, valid_out}, 32'd0);
        chk("arst_addr", imemaddr, 32'h0);
        sb.delete();
        nRST = 1'b1;
        step(1, 0, 0, 0, 0, 1, 32'h0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 32'h4, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
